param_johnson_counter: RTL and testbench

//   Parametrised synchronous Johnson (twisted-ring) counter; generalises the 4-stage down counter.

---
 rtl/param_johnson_counter.sv | 118 +++++++++++
 tb/tb_param_johnson_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_johnson_counter.sv
// Parametrised up/down Johnson counter with enable, phase load, wrap and load-error pulses.
// Optional self-correction of corrupted state when JOHNSON_SELF_CORRECT_EN is defined.
module param_johnson_counter #(
    parameter int  STAGES      = 4,
    parameter int  RESET_PHASE = 0,
    localparam int PW          = $clog2(2 * STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [PW-1:0]     load_phase,
    output logic [STAGES-1:0] out,
    output logic [PW-1:0]     phase,
    output logic              wrap,
    output logic              load_err
`ifdef JOHNSON_SELF_CORRECT_EN
    ,
    output logic              illegal
`endif
);

    localparam int            LEN       = 2 * STAGES;
    localparam logic [PW-1:0] LAST      = PW'(LEN - 1);
    localparam logic [PW-1:0] RST_PHASE = PW'(RESET_PHASE);

    // Phase p < N sets the lowest p bits; p >= N clears the lowest (p - N) bits.
    function automatic logic [STAGES-1:0] code_of(input logic [PW-1:0] p);
        logic [STAGES-1:0] c;
        int                pi;
        pi = int'(p);
        c  = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (pi < STAGES) c[i] = (i < pi);
            else             c[i] = (i >= pi - STAGES);
        end
        return c;
    endfunction

    logic [STAGES-1:0] out_q,   out_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              wrap_q,  wrap_d;
    logic              err_q,   err_d;
    logic              load_ok;

    assign load_ok = int'(load_phase) < LEN;

`ifdef JOHNSON_SELF_CORRECT_EN
    logic ill_q, ill_d;
    logic state_ok;

    assign state_ok = (int'(phase_q) < LEN) && (out_q == code_of(phase_q));
    assign illegal  = ill_q;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        out_d   = out_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
        ill_d   = 1'b0;
        if (!state_ok) begin
            out_d   = code_of(RST_PHASE);
            phase_d = RST_PHASE;
            ill_d   = 1'b1;
        end else
`endif
        if (load) begin
            if (load_ok) begin
                out_d   = code_of(load_phase);
                phase_d = load_phase;
            end else begin
                err_d   = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                out_d   = {out_q[STAGES-2:0], ~out_q[STAGES-1]};
                phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
                wrap_d  = (phase_q == LAST);
            end else begin
                out_d   = {~out_q[0], out_q[STAGES-1:1]};
                phase_d = (phase_q == '0) ? LAST : phase_q - PW'(1);
                wrap_d  = (phase_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            out_q   <= code_of(RST_PHASE);
            phase_q <= RST_PHASE;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

`ifdef JOHNSON_SELF_CORRECT_EN
    always_ff @(posedge clk) begin
        if (!rst) ill_q <= 1'b0;
        else      ill_q <= ill_d;
    end
`endif

    assign out      = out_q;
    assign phase    = phase_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_param_johnson_counter.sv
// Bench for param_johnson_counter: three instances (N=4, N=3, N=4 with RESET_PHASE=2) share
// one stimulus; a phase-integer model predicts every output each cycle.
module tb_param_johnson_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_phase = '0;

    logic [3:0] out_a, out_c;
    logic [2:0] out_b;
    logic [2:0] phase_a, phase_b, phase_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       err_a, err_b, err_c;
`ifdef JOHNSON_SELF_CORRECT_EN
    logic       ill_a, ill_b, ill_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    param_johnson_counter #(.STAGES(4), .RESET_PHASE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_phase(load_phase),
        .out(out_a), .phase(phase_a), .wrap(wrap_a), .load_err(err_a)
`ifdef JOHNSON_SELF_CORRECT_EN
        , .illegal(ill_a)
`endif
    );

    param_johnson_counter #(.STAGES(3), .RESET_PHASE(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_phase(load_phase),
        .out(out_b), .phase(phase_b), .wrap(wrap_b), .load_err(err_b)
`ifdef JOHNSON_SELF_CORRECT_EN
        , .illegal(ill_b)
`endif
    );

    param_johnson_counter #(.STAGES(4), .RESET_PHASE(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_phase(load_phase),
        .out(out_c), .phase(phase_c), .wrap(wrap_c), .load_err(err_c)
`ifdef JOHNSON_SELF_CORRECT_EN
        , .illegal(ill_c)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int n_of(int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic int rp_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // Johnson code of phase p: ones fill up from bit 0, then zeros fill up from bit 0.
    function automatic int code_model(int n, int p);
        if (p < n) return (1 << p) - 1;
        return ((1 << n) - 1) & ~((1 << (p - n)) - 1);
    endfunction

    int m_p[3];
    int m_w[3];
    int m_e[3];
    bit m_step;

    always @(posedge clk) begin
        m_step <= rst && !load && en;
        for (int k = 0; k < 3; k++) begin
            m_w[k] <= 0;
            m_e[k] <= 0;
            if (!rst) begin
                m_p[k] <= rp_of(k);
            end else if (load) begin
                if (int'(load_phase) < 2 * n_of(k)) m_p[k] <= int'(load_phase);
                else                                m_e[k] <= 1;
            end else if (en) begin
                if (up) begin
                    m_p[k] <= (m_p[k] + 1) % (2 * n_of(k));
                    m_w[k] <= int'(m_p[k] == 2 * n_of(k) - 1);
                end else begin
                    m_p[k] <= (m_p[k] + 2 * n_of(k) - 1) % (2 * n_of(k));
                    m_w[k] <= int'(m_p[k] == 0);
                end
            end
        end
    end

    function automatic int act_out(int k);
        case (k)
            0:       return int'(out_a);
            1:       return int'(out_b);
            default: return int'(out_c);
        endcase
    endfunction

    function automatic int act_phase(int k);
        case (k)
            0:       return int'(phase_a);
            1:       return int'(phase_b);
            default: return int'(phase_c);
        endcase
    endfunction

    function automatic int act_wrap(int k);
        case (k)
            0:       return int'(wrap_a);
            1:       return int'(wrap_b);
            default: return int'(wrap_c);
        endcase
    endfunction

    function automatic int act_err(int k);
        case (k)
            0:       return int'(err_a);
            1:       return int'(err_b);
            default: return int'(err_c);
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    logic [3:0] prev_a;
    bit         have_prev = 0;

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("out[%0d]", k),      act_out(k),   code_model(n_of(k), m_p[k]));
                check($sformatf("phase[%0d]", k),    act_phase(k), m_p[k]);
                check($sformatf("wrap[%0d]", k),     act_wrap(k),  m_w[k]);
                check($sformatf("load_err[%0d]", k), act_err(k),   m_e[k]);
            end
`ifdef JOHNSON_SELF_CORRECT_EN
            check("illegal_idle", int'(ill_a) + int'(ill_b) + int'(ill_c), 0);
`endif
            if (have_prev && m_step)
                check("one_bit_step", int'($countones(out_a ^ prev_a) <= 1), 1);
            prev_a    = out_a;
            have_prev = 1;
        end else begin
            have_prev = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic l, input logic [2:0] lp,
                       input logic e, input logic u);
        rst = r; load = l; load_phase = lp; en = e; up = u;
        @(posedge clk);
        #1;
    endtask

    int         exp_up[9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [15:0] dir_pat = 16'b0000_0111_0100_0011;

    initial begin
        // reset
        cyc(0, 0, 3'd0, 0, 1);
        checking = 1;
        check("reset_out_a",   int'(out_a),   4'b0000);
        check("reset_phase_a", int'(phase_a), 0);
        check("reset_out_c",   int'(out_c),   4'b0011);
        check("reset_phase_c", int'(phase_c), 2);
        check("reset_flags",   int'(wrap_a) + int'(err_a), 0);

        // count up through the wrap
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 3'd0, 1, 1);
            check($sformatf("up_out_%0d", i),   int'(out_a),   exp_up[i]);
            check($sformatf("up_phase_%0d", i), int'(phase_a), (i + 1) % 8);
            check($sformatf("up_wrap_%0d", i),  int'(wrap_a),  int'(i == 7));
        end

        // count down from reset
        cyc(0, 0, 3'd0, 0, 0);
        cyc(1, 0, 3'd0, 1, 0);
        check("down_out0",   int'(out_a),   4'b1000);
        check("down_phase0", int'(phase_a), 7);
        check("down_wrap0",  int'(wrap_a),  1);
        cyc(1, 0, 3'd0, 1, 0);
        check("down_out1",   int'(out_a),   4'b1100);
        check("down_wrap1",  int'(wrap_a),  0);

        // loads, including out-of-range on the 3-stage instance
        cyc(1, 1, 3'd5, 1, 1);
        check("load5_out_a",   int'(out_a),   4'b1110);
        check("load5_phase_a", int'(phase_a), 5);
        check("load5_out_b",   int'(out_b),   3'b100);
        cyc(1, 1, 3'd6, 1, 1);
        check("load6_out_a",   int'(out_a),   4'b1100);
        check("load6_wrap_a",  int'(wrap_a),  0);
        check("load6_err_b",   int'(err_b),   1);
        check("load6_phase_b", int'(phase_b), 5);
        cyc(1, 1, 3'd7, 1, 1);
        check("load7_err_b",   int'(err_b),   1);
        check("load7_out_b",   int'(out_b),   3'b100);
        cyc(1, 0, 3'd0, 0, 1);
        check("hold_err_b",    int'(err_b),   0);
        check("hold_out_a",    int'(out_a),   4'b1000);

        // direction reversals
        for (int i = 0; i < 16; i++) cyc(1, 0, 3'd0, 1, dir_pat[i]);

        // reset mid-count overrides load and enable
        cyc(0, 0, 3'd0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 3'd0, 1, 1);
        check("mid_phase_a", int'(phase_a), 3);
        cyc(0, 1, 3'd5, 1, 1);
        check("mid_rst_out_a",   int'(out_a),   4'b0000);
        check("mid_rst_phase_a", int'(phase_a), 0);
        check("mid_rst_out_c",   int'(out_c),   4'b0011);

        // mixed traffic
        for (int i = 0; i < 300; i++)
            cyc(logic'($urandom_range(0, 31) != 0), logic'($urandom_range(0, 7) == 0),
                3'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 1)));

`ifdef JOHNSON_SELF_CORRECT_EN
        cyc(0, 0, 3'd0, 0, 1);
        checking = 0;
        cyc(1, 0, 3'd0, 0, 1);
        @(negedge clk);
        force dut_a.out_q = 4'b0101;
        #1;
        release dut_a.out_q;
        cyc(1, 0, 3'd0, 1, 1);
        check("fix_out_a",   int'(out_a),   4'b0000);
        check("fix_phase_a", int'(phase_a), 0);
        check("fix_illegal", int'(ill_a),   1);
        cyc(1, 0, 3'd0, 1, 1);
        check("fix_next_out", int'(out_a), 4'b0001);
        check("fix_next_ill", int'(ill_a), 0);
        cyc(0, 0, 3'd0, 0, 1);
        checking = 1;
        for (int i = 0; i < 10; i++) cyc(1, 0, 3'd0, 1, 1);
`endif

        checking = 0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
